// File: rtl/out_uart_tx.sv
// ---------------------------------------------------------------------------
// out_uart_tx
//
// Output-side peripheral for the 16-bit pipelined core. Each output-port
// write is queued in a small FIFO. The head word is then sent on a UART TX
// line as two 8N1 frames, low byte first. The core cannot stall, so a write
// that arrives while the FIFO is full is dropped, and a sticky flag records
// the loss. The drained output tells the bench or board that a halted core
// has had all of its output transmitted.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   out_en    core output strobe, one word per cycle while high
//   out_dat   core output data, valid when out_en=1
//   is_halt   core halted (level)
//   txd       UART serial line, idle high (registered)
//   busy      transmitter not idle (registered)
//   overflow  sticky: at least one write was dropped
//   count     FIFO occupancy after the most recent edge
//   drained   is_halt && count==0 && !busy
// ---------------------------------------------------------------------------
module out_uart_tx #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_en,
  input  logic [15:0]              out_dat,
  input  logic                     is_halt,
  output logic                     txd,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  logic [15:0]   head;

  // Transmitter
  state_e        state_q;
  logic          byte_sel_q;   // 0 = low byte in flight, 1 = high byte
  logic [15:0]   shift_q;
  logic [2:0]    bit_idx_q;
  logic [BW-1:0] baud_q;
  logic          txd_q;
  logic          busy_q;
  logic          baud_last;

  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // The transmitter takes a word only from IDLE, so a pop is always
  // followed by at least 20 bit times before the next one can occur.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = out_en && ((count_q != CW'(DEPTH)) || pop);

  // NOTE: every signal gets a default before any conditional update, so
  // this block can never infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (out_en & ~push);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset. The pointers
  // and count define which entries are valid, and leaving the array
  // unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= out_dat;
  end

  // Serialiser. txd and busy are registered directly in the state machine.
  // shift_q moves right once per data bit. After the low byte's eight
  // shifts, the high byte already sits in shift_q[7:0] for the second frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_sel_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= head;
            byte_sel_q <= 1'b0;
            baud_q     <= '0;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (!byte_sel_q) begin
              // Second frame starts with no gap after the first stop bit
              byte_sel_q <= 1'b1;
              txd_q      <= 1'b0;
              state_q    <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign drained  = is_halt && (count_q == '0) && !busy_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_out_uart_tx
//
// Bench for out_uart_tx with DEPTH=4 and CLKS_PER_BIT=4. A reference model
// runs alongside the DUT. It keeps the queued words, the overflow flag and
// the edge at which the current word was taken. From these it computes the
// expected txd bit with frame arithmetic, and it also predicts busy, count
// and drained on every cycle. A table of overflow vectors and several
// hand-written sequences cover latency, gap timing, full-FIFO push/pop,
// drained and reset abort. A randomized run follows.
// ---------------------------------------------------------------------------
module tb_out_uart_tx;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;
  localparam int WORD  = 20 * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_en = 1'b0;
  logic [15:0] out_dat = '0;
  logic        is_halt = 1'b0;
  logic        txd, busy, overflow, drained;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  out_uart_tx #(.DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_en   (out_en),
    .out_dat  (out_dat),
    .is_halt  (is_halt),
    .txd      (txd),
    .busy     (busy),
    .overflow (overflow),
    .count    (count),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ------------------------------------------------------------------
  // Reference model: transmitted word w, taken at edge p, occupies edges
  // p .. p+WORD-1. Position k = edge - p selects the frame (k / FRAME)
  // and the bit slot within it ((k % FRAME) / C).
  // ------------------------------------------------------------------
  int          cyc = 0;
  logic [15:0] mq[$];
  int          last_pop = -1;
  logic [15:0] cur_word = '0;
  bit          m_ovf = 1'b0;
  bit          mon_en = 1'b0;
  int          m_occ, m_k, m_slot;
  bit          m_pop;
  logic        exp_txd, exp_busy, exp_drained;
  logic [7:0]  m_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      last_pop = -1;
      m_ovf    = 1'b0;
    end else begin
      m_occ = mq.size();
      m_pop = (m_occ > 0) && ((last_pop < 0) || (cyc >= last_pop + WORD + 1));
      if (m_pop) begin
        cur_word = mq.pop_front();
        last_pop = cyc;
      end
      if (out_en) begin
        if (m_occ < D || m_pop) mq.push_back(out_dat);
        else m_ovf = 1'b1;
      end
    end
    exp_txd  = 1'b1;
    exp_busy = 1'b0;
    if (last_pop >= 0 && (cyc - last_pop) < WORD) begin
      m_k      = cyc - last_pop;
      exp_busy = 1'b1;
      m_byte   = (m_k < FRAME) ? cur_word[7:0] : cur_word[15:8];
      m_slot   = (m_k % FRAME) / C;
      if (m_slot == 0)      exp_txd = 1'b0;
      else if (m_slot == 9) exp_txd = 1'b1;
      else                  exp_txd = m_byte[m_slot-1];
    end
    #1;
    if (mon_en) begin
      exp_drained = is_halt && (mq.size() == 0) && !exp_busy;
      check("model_txd", txd, exp_txd);
      check("model_busy", busy, exp_busy);
      check("model_count", count, mq.size());
      check("model_overflow", overflow, m_ovf);
      check("model_drained", drained, exp_drained);
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge, outputs are
  // sampled 1 time unit after the rising edge.
  // ------------------------------------------------------------------
  task automatic drive(input logic en, input logic [15:0] dat);
    @(negedge clk);
    out_en  = en;
    out_dat = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset  = 1'b1;
    out_en = 1'b0;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while ((busy !== 1'b0 || count !== 3'd0) && t < limit) begin
      step();
      t++;
    end
    check("drain_in_time", (t < limit), 1);
  endtask

  typedef struct {
    logic        en;
    logic [15:0] dat;
    logic [2:0]  exp_count;
    logic        exp_ovf;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[8];

  logic [7:0] lo_byte, hi_byte;
  int         burst;

  initial begin
    // Overflow table: six back-to-back writes into a 4-deep FIFO
    tbl[0] = '{1'b1, 16'd1, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'd2, 3'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'd3, 3'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'd4, 3'd3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'd5, 3'd4, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 16'd6, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 16'd0, 3'd4, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'd0, 3'd4, 1'b1, 1'b1};

    // ---- reset state ----
    reset_dut();
    mon_en = 1'b1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drained_nohalt", drained, 0);
    @(negedge clk);
    is_halt = 1'b1;
    #1;
    check("rst_drained_halt", drained, 1);
    is_halt = 1'b0;

    // ---- single word 0xA55A ----
    lo_byte = 8'h5A;
    hi_byte = 8'hA5;
    drive(1'b1, 16'hA55A);
    step();                                   // edge 0
    check("w1_e0_count", count, 1);
    check("w1_e0_txd", txd, 1);
    drive(1'b0, 16'h0);
    step();                                   // edge 1
    check("w1_e1_txd_start", txd, 0);
    check("w1_e1_count", count, 0);
    check("w1_e1_busy", busy, 1);
    repeat (3) step();                        // edge 4
    check("w1_e4_start_held", txd, 0);
    step();                                   // edge 5
    check("w1_lo_bit0", txd, lo_byte[0]);
    for (int b = 1; b < 8; b++) begin
      repeat (C) step();
      check($sformatf("w1_lo_bit%0d", b), txd, lo_byte[b]);
    end
    repeat (C) step();                        // edge 37
    check("w1_lo_stop", txd, 1);
    repeat (C) step();                        // edge 41
    check("w1_hi_start", txd, 0);
    for (int b = 0; b < 8; b++) begin
      repeat (C) step();
      check($sformatf("w1_hi_bit%0d", b), txd, hi_byte[b]);
    end
    repeat (C) step();                        // edge 77
    check("w1_hi_stop", txd, 1);
    repeat (3) step();                        // edge 80
    check("w1_e80_busy", busy, 1);
    step();                                   // edge 81
    check("w1_e81_busy", busy, 0);
    check("w1_e81_txd", txd, 1);

    // ---- back-to-back writes: one idle cycle between words ----
    drive(1'b1, 16'h0001);
    step();                                   // edge 0
    check("b2b_e0_count", count, 1);
    drive(1'b1, 16'h0002);
    step();                                   // edge 1
    check("b2b_e1_count", count, 1);
    check("b2b_e1_txd", txd, 0);
    drive(1'b0, 16'h0);
    repeat (79) step();                       // edge 80
    check("b2b_e80_busy", busy, 1);
    step();                                   // edge 81: the single idle cycle
    check("b2b_e81_busy", busy, 0);
    check("b2b_e81_txd", txd, 1);
    check("b2b_e81_count", count, 1);
    step();                                   // edge 82: second start bit
    check("b2b_e82_txd", txd, 0);
    check("b2b_e82_busy", busy, 1);
    check("b2b_e82_count", count, 0);
    check("b2b_overflow", overflow, 0);
    wait_drain(200);

    // ---- table: overflow with 6 writes into DEPTH=4 ----
    reset_dut();
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].dat);
      step();
      check($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end
    drive(1'b0, 16'h0);
    wait_drain(600);
    check("tbl_overflow_sticky", overflow, 1);

    // ---- push and pop together while full ----
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0011 + 16'(i));
      step();
    end
    check("full_count", count, 4);
    drive(1'b0, 16'h0);
    for (int t = 0; t < 200 && busy !== 1'b0; t++) step();
    check("full_idle_reached", busy, 0);
    drive(1'b1, 16'h0099);
    step();                                   // pop edge with a push
    check("full_pushpop_count", count, 4);
    check("full_pushpop_overflow", overflow, 0);
    check("full_pushpop_txd", txd, 0);
    drive(1'b0, 16'h0);
    wait_drain(600);
    check("full_final_overflow", overflow, 0);

    // ---- drained after halt with two queued words ----
    reset_dut();
    is_halt = 1'b1;
    drive(1'b1, 16'hBEEF);
    step();                                   // edge 0
    check("halt_e0_drained", drained, 0);
    drive(1'b1, 16'hCAFE);
    step();                                   // edge 1
    drive(1'b0, 16'h0);
    repeat (160) step();                      // edge 161
    check("halt_e161_drained", drained, 0);
    check("halt_e161_busy", busy, 1);
    step();                                   // edge 162
    check("halt_e162_drained", drained, 1);
    check("halt_e162_busy", busy, 0);
    @(negedge clk);
    is_halt = 1'b0;
    #1;
    check("halt_released_drained", drained, 0);

    // ---- reset in the middle of the high byte's data bits ----
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h0100 + 16'(i));
      step();
    end
    check("abort_pre_overflow", overflow, 1);
    drive(1'b0, 16'h0);
    repeat (50) step();                       // edge 55, high byte data
    check("abort_pre_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) step();
    check("abort_quiet_busy", busy, 0);
    check("abort_quiet_txd", txd, 1);

    // ---- randomized traffic against the model ----
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(2, 7);
      if (burst > 0) begin
        out_en = 1'b1;
        burst--;
      end else begin
        out_en = ($urandom_range(0, 39) == 0);
      end
      out_dat = 16'($urandom);
      if ($urandom_range(0, 99) == 0) is_halt = ~is_halt;
    end
    @(negedge clk);
    reset  = 1'b0;
    out_en = 1'b0;
    wait_drain(600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Output-side peripheral directly downstream of the 16-bit pipelined core.
- Consumes the core's output-port writes (out_en/out_dat) and buffers them in a FIFO.
- Serialises each word onto a UART TX line as two 8N1 frames, low byte first.
- The core has no stall input, so writes to a full FIFO are dropped and flagged; a drained indication lets the bench or board detect end-of-run after is_halt.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
CLKS_PER_BIT, 434, clock cycles per UART bit; >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
out_en  input  1  core output strobe; one word per cycle when high
out_dat  input  16  core output data, valid when out_en=1
is_halt  input  1  core halted (level)
txd  output  1  UART serial line, idle high
busy  output  1  FSM not in IDLE
overflow  output  1  sticky: a write was dropped
count  output  $clog2(DEPTH)+1  current FIFO occupancy
drained  output  1  is_halt && count==0 && !busy

Behaviour:
- Reset (synchronous, active-high): txd=1, busy=0, overflow=0, count=0, FIFO pointers 0, FSM=IDLE, bit and baud counters 0. A frame in progress is aborted immediately; txd returns high on the same edge.
- FIFO push/pop:
  - Push when out_en=1 and (count<DEPTH or pop this cycle).
  - If out_en=1, count==DEPTH and no pop: word is dropped, overflow<=1. overflow clears only on reset.
  - Simultaneous push and pop: count unchanged, both occur.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP, plus a 1-bit byte-select (0=low byte, 1=high byte).
  - IDLE: txd=1. If count>0 at an edge: pop head into a 16-bit shift word, byte-select<=0, go to START, txd<=0.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with txd=bit0.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles. After bit7, go to STOP, txd=1.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. Then:
    - if byte-select=0: byte-select<=1, go to START (no gap between the two bytes);
    - else: go to IDLE.
- Timing:
  - Each frame is 10*CLKS_PER_BIT cycles; each word is 20*CLKS_PER_BIT cycles.
  - Consecutive words are separated by exactly one IDLE cycle of txd=1.
- Latency: word pushed at edge E0 is popped at edge E0+1 if the FSM is IDLE and FIFO was empty; txd falls at that edge.
- Baud counter runs 0..CLKS_PER_BIT-1; state/bit advance when counter==CLKS_PER_BIT-1.
- busy=1 in all states except IDLE. count reflects post-edge occupancy.
- drained is combinational from is_halt, count and busy.
- is_halt does not stop draining; queued words are always transmitted.

Test Plan:
- CLKS_PER_BIT=4; single out_en pulse with out_dat=0xA55A at edge 0 -> txd low from edge 1 for 4 cycles, then bits of 0x5A LSB first (0,1,0,1,1,0,1,0), each 4 cycles, stop 4 cycles, immediately followed by a frame for 0xA5; busy falls at edge 81; count returns to 0 at edge 1.
- Back-to-back writes 0x0001, 0x0002 on consecutive cycles -> count peaks at 1; second word's start bit begins exactly one idle cycle after first word's final stop bit; overflow stays 0.
- DEPTH=4; out_en high for 6 consecutive cycles with data 1..6 -> word 1 popped at edge 1; count sequence 1,1,2,3,4,4; word 6 dropped, overflow=1; transmitted sequence is 1,2,3,4,5; overflow stays 1 afterwards.
- Simultaneous push and pop at full (DEPTH=4, FIFO full, FSM finishing a word) -> count stays 4, no overflow, new word transmitted last in order.
- is_halt=1 with 2 words queued -> drained=0 until the final stop bit ends and FSM enters IDLE, then drained=1 the same cycle busy=0.
- Reset asserted mid-DATA of the high byte -> next edge: txd=1, busy=0, count=0, overflow=0; no further frames without a new write.
